// File: rtl/ahb_apb_slave_frontend.sv
// AHB slave front-end for the AHB-to-APB bridge: decodes NUM_SLV equal regions, captures one
// request at a time for the APB-side FSM and stretches the AHB data phase until it responds.
module ahb_apb_slave_frontend #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                NUM_SLV     = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] REGION_SIZE = 32'h0400_0000
) (
    input  logic              Hclk,
    input  logic              Hreset,
    input  logic              Hwrite,
    input  logic              Hreadyin,
    input  logic [1:0]        Htrans,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic [DATA_W-1:0] Hwdata,
    output logic              Hreadyout,
    output logic [1:0]        Hresp,
    output logic [DATA_W-1:0] Hrdata,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_write,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    output logic [NUM_SLV-1:0] req_selx,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_rdata,
    input  logic              rsp_err
);

    // state | meaning
    // IDLE  | no transfer in progress, ready for an address phase
    // DATA  | AHB data phase of a mapped transfer, write data captured here
    // REQ   | request offered to the APB side, waiting for req_ready
    // WAIT  | request accepted, waiting for rsp_valid
    // DONE  | OKAY completion cycle, next address phase may be taken
    // ERR1  | first ERROR cycle, Hreadyout low
    // ERR2  | second ERROR cycle, next address phase may be taken
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DATA = 3'd1,
        REQ  = 3'd2,
        WAIT = 3'd3,
        DONE = 3'd4,
        ERR1 = 3'd5,
        ERR2 = 3'd6
    } state_t;

    localparam int               SHIFT   = $clog2(REGION_SIZE);
    localparam logic [ADDR_W:0]  ADDR_LO = {1'b0, BASE_ADDR};
    localparam logic [ADDR_W:0]  ADDR_HI = ADDR_LO + {1'b0, REGION_SIZE} * (ADDR_W+1)'(NUM_SLV);

    state_t               state;
    state_t               state_nxt;
    logic                 xfer_valid;
    logic                 accept_state;
    logic                 mapped;
    logic                 take;
    logic [ADDR_W-1:0]    offset;
    logic [ADDR_W-1:0]    idx;
    logic [NUM_SLV-1:0]   sel_dec;
    logic [NUM_SLV-1:0]   selx_q;

    assign xfer_valid   = Hreadyin && (Htrans == 2'b10 || Htrans == 2'b11);
    assign accept_state = (state == IDLE) || (state == DONE) || (state == ERR2);

    // one extra bit keeps the upper bound from wrapping near the top of the address map
    assign mapped = ({1'b0, Haddr} >= ADDR_LO) && ({1'b0, Haddr} < ADDR_HI);
    assign take   = accept_state && xfer_valid && mapped;
    assign offset = Haddr - BASE_ADDR;
    assign idx    = offset >> SHIFT;

    always_comb begin
        sel_dec = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            sel_dec[i] = (idx == ADDR_W'(i));
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERR2: begin
                if (xfer_valid) state_nxt = mapped ? DATA : ERR1;
                else            state_nxt = IDLE;
            end
            DATA: state_nxt = REQ;
            REQ:  if (req_ready) state_nxt = WAIT;
            WAIT: if (rsp_valid) state_nxt = rsp_err ? ERR1 : DONE;
            ERR1: state_nxt = ERR2;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state     <= IDLE;
            req_write <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            selx_q    <= '0;
            Hrdata    <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                req_addr  <= Haddr;
                req_write <= Hwrite;
                selx_q    <= sel_dec;
            end
            if (state == DATA && req_write) req_wdata <= Hwdata;
            if (state == WAIT && rsp_valid && !rsp_err && !req_write) Hrdata <= rsp_rdata;
        end
    end

    // select is only visible while the request is being formed or offered
    assign req_selx  = (state == DATA || state == REQ) ? selx_q : '0;
    assign req_valid = (state == REQ);
    assign Hreadyout = accept_state;
    assign Hresp     = (state == ERR1 || state == ERR2) ? 2'b01 : 2'b00;

endmodule
